// File: rtl/shift_add_mult32.sv
// shift_add_mult32: iterative unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
// It performs one shift-and-add step per clock through an external ripple-carry
// adder that is reached via the add_* ports. The accumulator {hi,lo} shifts
// right by one bit each step. The adder's carry-out is kept as the new hi MSB,
// so the 33-bit partial sum is never truncated.
module shift_add_mult32 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_carry
);

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CNT_W-1:0]   r_count;
  logic               w_load;
  logic               w_step;

  // An accepted start is any start seen outside RUN; the operands are captured on that edge
  assign w_load = start && (r_state != RUN);
  assign w_step = (r_state == RUN);

  // Adder operands come straight from the registers: hi plus the gated multiplicand
  assign add_a   = r_hi;
  assign add_b   = r_lo[0] ? r_mcand : '0;
  assign add_cin = 1'b0;

  assign product = {r_hi, r_lo};

  // State register; reset aborts any multiply in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status outputs; DONE lasts exactly one cycle
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_count == LAST_STEP) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? RUN : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: load on an accepted start, otherwise one shift-and-add per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_mcand <= a;
      r_hi    <= '0;
      r_lo    <= b;
      r_count <= '0;
    end else if (w_step) begin
      // The carry-out becomes the new hi MSB; the sum LSB shifts into lo
      r_hi    <= {add_carry, add_sum[WIDTH-1:1]};
      r_lo    <= {add_sum[0], r_lo[WIDTH-1:1]};
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_add_mult32.sv
// Bench for shift_add_mult32. It closes the adder loop with a behavioural
// 32-bit adder, applies a table of directed vectors, and then runs the
// multi-cycle corner sequences.
module tb_shift_add_mult32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_carry;

  int ntests = 0;
  int nfail  = 0;

  shift_add_mult32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_carry (add_carry)
  );

  // External 32-bit adder with carry-out
  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Start one multiply; report the product, the edge count from the accepting
  // edge (inclusive) to the done sample, and the number of busy cycles
  task automatic do_mult(input logic [31:0] ta, input logic [31:0] tb_v,
                         output logic [63:0] p, output int lat, output int nbusy);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    nbusy = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) nbusy++;
    end
    p = product;
  endtask

  vec_t        vecs[7];
  logic [63:0] p;
  int          lat;
  int          nbusy;
  int          ndone;
  int          done_at[2];
  logic [63:0] prod_at[2];
  logic        prev_done;
  int          consec;

  initial begin
    vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,          32'hDEAD_BEEF,  64'h0};
    vecs[3] = '{32'h1234_5678,  32'd1,          64'h0000_0000_1234_5678};
    vecs[4] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
    vecs[5] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
    vecs[6] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_product", product,      64'd0);
    check("rst_add_a",   64'(add_a),   64'd0);
    check("rst_add_b",   64'(add_b),   64'd0);
    check("rst_add_cin", 64'(add_cin), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      do_mult(vecs[i].va, vecs[i].vb, p, lat, nbusy);
      check($sformatf("vec%0d_product", i), p, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d_busy_cycles", i), 64'(nbusy), 64'd32);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      check($sformatf("vec%0d_hold", i), product, vecs[i].exp);
    end

    // Start ignored while busy: 7 x 9 with disruptive starts at steps 5 and 20
    @(negedge clk);
    a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 5 || lat == 20) begin
        start = 1'b1; a = 32'hFFFF; b = 32'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("ign_latency", 64'(lat), 64'd33);
    check("ign_product", product, 64'd63);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("ign_no_second_run", 64'(ndone), 64'd0);
    check("ign_hold", product, 64'd63);

    // Back-to-back with start held high
    @(negedge clk);
    a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd4; b = 32'd5;
    lat = 1; ndone = 0; prev_done = 1'b0; consec = 0;
    done_at[0] = 0; done_at[1] = 0; prod_at[0] = '0; prod_at[1] = '0;
    while (lat < 80) begin
      @(posedge clk); #1;
      lat++;
      if (done && prev_done) consec++;
      if (done && ndone < 2) begin
        done_at[ndone] = lat;
        prod_at[ndone] = product;
        ndone++;
        if (ndone == 2) start = 1'b0;
      end
      prev_done = done;
    end
    start = 1'b0;
    check("b2b_first_done",   64'(done_at[0]), 64'd33);
    check("b2b_first_prod",   prod_at[0],      64'd6);
    check("b2b_second_done",  64'(done_at[1]), 64'd66);
    check("b2b_second_prod",  prod_at[1],      64'd20);
    check("b2b_no_consec",    64'(consec),     64'd0);

    // Reset asserted between edges during RUN step 10
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h9ABC_DEF1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int s = 1; s < 10; s++) begin
      @(posedge clk); #1;
    end
    check("mid_busy_before", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy",    64'(busy),    64'd0);
    check("mid_rst_done",    64'(done),    64'd0);
    check("mid_rst_product", product,      64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_mult(32'd11, 32'd13, p, lat, nbusy);
    check("post_rst_product", p,        64'd143);
    check("post_rst_latency", 64'(lat), 64'd33);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
